// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file, decoder and hazard unit.
package regfile_pkg;

  // Index of the hardwired zero register
  localparam int ZERO_REG = 0;

  // Default datapath geometry shared across the pipeline
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  // Reset contents of register idx.
  // r0 always resets to zero. The caller casts the result to its data width,
  // which zero-extends or truncates it.
  function automatic logic [31:0] init_value(input int unsigned idx, input bit init_index);
    logic [31:0] val;
    if (init_index && (idx != ZERO_REG)) begin
      val = idx;
    end else begin
      val = 32'd0;
    end
    return val;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets a bit, write-back clears it,
// reserve wins on collision, bit 0 is tied low.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reserve_en_i,
  input  logic [ADDR_W-1:0]      reserve_register_i,
  input  logic                   reg_write_i,
  input  logic [ADDR_W-1:0]      write_register_i,
  output logic [2**ADDR_W-1:0]   busy_o,
  output logic                   any_busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector.
  // A new producer (reserve) has priority over the retiring one (write-back).
  always_comb begin
    busy_d = busy_q;
    busy_d[ZERO_REG] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (reserve_en_i && (reserve_register_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (reg_write_i && (write_register_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy vector register.
  // Synchronous reset clears every pending producer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: one synchronous write port and two
// combinational read ports, with an optional write-to-read bypass,
// a hardwired r0 with an error pulse and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_register,
  output logic              busy_1,
  output logic              busy_2,
  output logic              any_busy,
  output logic              write_zero_err
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam bit                BYP_EN    = (BYPASS != 0);
  localparam bit                INIT_EN   = (INIT_INDEX != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              write_zero_err_q;
  logic              write_zero_err_d;
  logic              write_ok_s;
  logic              hit_1_s;
  logic              hit_2_s;
  logic [DEPTH-1:0]  busy_vec_s;

  // A write only takes effect when it targets a real register.
  assign write_ok_s = reg_write && (write_register != ZERO_ADDR);
  assign hit_1_s    = BYP_EN && write_ok_s && (write_register == read_register_1);
  assign hit_2_s    = BYP_EN && write_ok_s && (write_register == read_register_2);

  // Storage array.
  // Reset loads the index pattern (or zeros); r0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= DATA_W'(init_value(i, INIT_EN));
      end
    end else if (write_ok_s) begin
      regs_q[write_register] <= write_data;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Read port 1: r0 reads zero, then the bypass, then stored contents.
  always_comb begin
    read_data_1 = regs_q[read_register_1];
    if (read_register_1 == ZERO_ADDR) begin
      read_data_1 = '0;
    end else if (hit_1_s) begin
      read_data_1 = write_data;
    end else begin
      read_data_1 = regs_q[read_register_1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    read_data_2 = regs_q[read_register_2];
    if (read_register_2 == ZERO_ADDR) begin
      read_data_2 = '0;
    end else if (hit_2_s) begin
      read_data_2 = write_data;
    end else begin
      read_data_2 = regs_q[read_register_2];
    end
  end

  // An attempted write to r0 raises the error flag for the next cycle.
  always_comb begin
    write_zero_err_d = 1'b0;
    if (reg_write && (write_register == ZERO_ADDR)) begin
      write_zero_err_d = 1'b1;
    end else begin
      write_zero_err_d = 1'b0;
    end
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_zero_err_q <= 1'b0;
    end else begin
      write_zero_err_q <= write_zero_err_d;
    end
  end

  assign write_zero_err = write_zero_err_q;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk                (clk),
    .rst_n              (rst_n),
    .reserve_en_i       (reserve_en),
    .reserve_register_i (reserve_register),
    .reg_write_i        (reg_write),
    .write_register_i   (write_register),
    .busy_o             (busy_vec_s),
    .any_busy_o         (any_busy)
  );

  // A bypassed write retires the producer this cycle, so hide its busy bit.
  assign busy_1 = busy_vec_s[read_register_1] && !hit_1_s;
  assign busy_2 = busy_vec_s[read_register_2] && !hit_2_s;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 register file in the MIPS datapath.
- Provides one synchronous write port and two asynchronous read ports, with width and depth set by parameters.
- Adds synchronous active-low reset with defined initial contents, optional write-to-read bypass, a hardwired zero register with an error pulse, and a per-register busy scoreboard.
- The scoreboard lets the pipeline's hazard unit detect reads of registers whose producer has not yet written back.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 3, register address width; depth is 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads always return stored contents.
- INIT_INDEX, 1, 1 = reset loads register i with value i, zero-extended or truncated to DATA_W; 0 = reset loads all zeros.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- reg_write  input  1  write enable.
- write_register  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- read_register_1  input  ADDR_W  read address, port 1.
- read_data_1  output  DATA_W  read data, port 1 (combinational).
- read_register_2  input  ADDR_W  read address, port 2.
- read_data_2  output  DATA_W  read data, port 2 (combinational).
- reserve_en  input  1  marks reserve_register as having a pending producer.
- reserve_register  input  ADDR_W  register to reserve.
- busy_1  output  1  scoreboard status of read_register_1.
- busy_2  output  1  scoreboard status of read_register_2.
- any_busy  output  1  OR of all busy bits.
- write_zero_err  output  1  registered one-cycle pulse on an attempted write to r0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). Reset takes priority over every other input.
- Reset, on a posedge with rst_n=0:
  - registers[i] <= INIT_INDEX ? i : 0; r0 is always 0.
  - All busy bits <= 0.
  - write_zero_err <= 0.
- Reset mid-operation: reserves and writes presented in the reset cycle are discarded.
- Write, on a posedge with rst_n=1, reg_write=1 and write_register!=0: registers[write_register] <= write_data. Contents are visible on the read ports from the next cycle.
- Write to r0, with reg_write=1 and write_register==0:
  - No register update.
  - write_zero_err=1 for exactly the next cycle.
  - reg_write=0 never raises the error, whatever the address.
- Read: read_data_k = registers[read_register_k], combinational. Reading r0 always returns 0.
- Bypass (BYPASS=1): if reg_write=1, write_register!=0 and write_register==read_register_k, then read_data_k = write_data in the same cycle. Both ports may bypass at once.
- Scoreboard, one bit per register; bit 0 is constant 0. On each posedge with rst_n=1, for each register i != 0:
  - Set if reserve_en=1 and reserve_register==i.
  - Otherwise cleared if reg_write=1 and write_register==i.
  - Otherwise held.
- Simultaneous reserve and write to the same register: reserve wins and the bit stays 1, since a new producer was issued.
- Reserving an already-busy register: the bit stays 1. There is no counting; only one outstanding producer per register is supported.
- Reserving r0 is ignored.
- A write to a non-busy register is legal and leaves its bit 0.
- busy_k = busy[read_register_k], except it is forced to 0 when BYPASS=1 and this cycle's write to read_register_k bypasses. With BYPASS=0 a clearing write still reports busy=1 in its own cycle.
- any_busy is the OR of the registered busy bits; it is not bypass-adjusted.
- Latency: write to read is 0 cycles with bypass and 1 cycle without. Reserve to busy is 1 cycle.

Decomposition:
- Package regfile_pkg:
  - ZERO_REG = 0.
  - Default DATA_W and ADDR_W constants shared with the decoder and the hazard unit.
  - A function init_value(i) implementing the INIT_INDEX rule.
- Sub-module regfile_scoreboard holds the busy bit vector, the set/clear priority logic and any_busy. The top level holds the storage array, bypass muxing and write_zero_err.

Test Plan:
- Reset: hold rst_n=0 for one posedge with INIT_INDEX=1, then read r0..r7 -> data 0..7, all busy=0, write_zero_err=0.
- Write/bypass: write r3=16'hBEEF with read_register_1=3.
  - BYPASS=1 -> read_data_1=BEEF in the same cycle.
  - BYPASS=0 -> read_data_1=3 in that cycle and BEEF the next cycle.
- Zero register: reg_write=1, write_register=0, data=FFFF -> r0 still reads 0 and write_zero_err=1 for exactly one cycle. The same cycle with reg_write=0 -> no pulse.
- Scoreboard: reserve r5, then read r5 the next cycle -> busy_1=1 and any_busy=1. Write r5 -> busy_1=0 that cycle (BYPASS=1); any_busy=0 the next cycle.
- Collision: reserve r2 and write r2 in the same cycle -> r2 updated and busy[2]=1 afterwards. Reserve r0 -> any_busy stays 0.
- Mid-op reset: set r4 busy and write r6=1234, then apply rst_n=0 together with a reserve of r1 -> r6=6, r4 and r1 not busy.
